// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target: FSM state encoding and the default fill word.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } spi_state_e;

    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam logic [MAX_DATA_WIDTH-1:0] DEFAULT_FILL = {MAX_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Edges are suppressed until the chain has refilled after reset, so a level held across reset never looks like an edge.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned FILL_W = $clog2(STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(STAGES + 1);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic [STAGES:0]   chain_ext_s;
    logic              prev_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              armed_s;

    // Next-state for the chain, the refill counter and the edge outputs.
    always_comb begin
        chain_ext_s = {chain_q, d_i};
        chain_d     = chain_ext_s[STAGES-1:0];
        armed_s     = (fill_q == FILL_DONE);
        if (armed_s) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FILL_W'(1);
        end
        q_o    = chain_q[STAGES-1];
        rise_o = armed_s & q_o & ~prev_q;
        fall_o = armed_s & ~q_o & prev_q;
    end

    // Synchronizer flops, previous-level flop and refill counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            fill_q  <= {FILL_W{1'b0}};
        end else begin
            chain_q <= chain_d;
            prev_q  <= chain_q[STAGES-1];
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a one-word TX holding register and word-wise RX output.
// Optional macro SPI_TARGET_UNDERRUN_EN adds a sticky underrun flag with its clear input.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD   = DEFAULT_FILL[DATA_WIDTH-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  mosi_i,
    input  logic                  cs_n_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  active_o
`ifdef SPI_TARGET_UNDERRUN_EN
    , input  logic                tx_underrun_clr_i
    , output logic                tx_underrun_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic cs_s, cs_rise_s, cs_fall_s;
    logic mosi_s, active_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES:0]   mosi_ext_s;

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_empty_q, hold_empty_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] reload_s;
    logic                  consume_s, accept_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sclk_i),
        .q_o    (sclk_s),
        .rise_o (sclk_rise_s),
        .fall_o (sclk_fall_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cs_n_i),
        .q_o    (cs_s),
        .rise_o (cs_rise_s),
        .fall_o (cs_fall_s)
    );

    // Frame FSM, bit counter and shift registers; CS_n rise overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        consume_s  = 1'b0;
        mosi_ext_s = {mosi_sync_q, mosi_i};
        mosi_s     = mosi_sync_q[SYNC_STAGES-1];
        active_s   = ~cs_s;
        reload_s   = hold_empty_q ? FILL_WORD : hold_q;

        case (state_q)
            ST_IDLE: begin
                tx_shift_d = reload_s;
                cnt_d      = {CNT_W{1'b0}};
                // Mode 0: a frame only opens while SCLK idles low.
                if (cs_fall_s && !sclk_s) begin
                    state_d   = ST_SHIFT;
                    consume_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        cnt_d      = {CNT_W{1'b0}};
                        state_d    = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_s) begin
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    tx_shift_d = tx_shift_q;
                end
            end
            ST_DRAIN: begin
                if (sclk_fall_s) begin
                    tx_shift_d = reload_s;
                    consume_s  = 1'b1;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cs_rise_s) begin
            state_d    = ST_IDLE;
            cnt_d      = {CNT_W{1'b0}};
            tx_shift_d = reload_s;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
            consume_s  = 1'b0;
        end else begin
            state_d = state_d;
        end

        miso_d = active_s ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
    end

    // Holding register: a consume of an empty register still lets a same-cycle TX word in.
    always_comb begin
        accept_s     = tx_valid_i & hold_empty_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        if (consume_s) begin
            hold_empty_d = ~accept_s;
            hold_d       = accept_s ? tx_data_i : hold_q;
        end else if (accept_s) begin
            hold_empty_d = 1'b0;
            hold_d       = tx_data_i;
        end else begin
            hold_empty_d = hold_empty_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            tx_shift_q   <= FILL_WORD;
            rx_shift_q   <= {DATA_WIDTH{1'b0}};
            hold_q       <= {DATA_WIDTH{1'b0}};
            hold_empty_q <= 1'b1;
            rx_data_q    <= {DATA_WIDTH{1'b0}};
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            mosi_sync_q  <= {SYNC_STAGES{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            miso_q       <= miso_d;
            mosi_sync_q  <= mosi_ext_s[SYNC_STAGES-1:0];
        end
    end

`ifdef SPI_TARGET_UNDERRUN_EN
    logic underrun_q, underrun_d;

    // Sticky flag set when a frame has to fall back to the fill word; clear has priority.
    always_comb begin
        if (tx_underrun_clr_i) begin
            underrun_d = 1'b0;
        end else if (consume_s && hold_empty_q) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Underrun flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign tx_underrun_o = underrun_q;
`endif

    assign miso_o     = miso_q;
    assign tx_ready_o = hold_empty_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign active_o   = active_s;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI initiator, a word-level model of the holding register and
// an RX scoreboard checked every cycle, plus literal expectations for the reference transfers.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst_n, sclk, mosi, cs_n, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, active;
`ifdef SPI_TARGET_UNDERRUN_EN
    logic       und_clr, und;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    int         rx_pulses = 0;
    int         pulses_before;

    bit         hold_v;
    logic [7:0] hold_w;
    bit         und_exp;
    logic [7:0] rx_exp[$];
    logic [7:0] mosi_tx[5];
    logic [7:0] miso_got[5];
    logic [7:0] miso_exp[5];

    always #5 clk = ~clk;

    spi_target dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sclk_i     (sclk),
        .mosi_i     (mosi),
        .cs_n_i     (cs_n),
        .miso_o     (miso),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .active_o   (active)
`ifdef SPI_TARGET_UNDERRUN_EN
        , .tx_underrun_clr_i(und_clr)
        , .tx_underrun_o    (und)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each consume takes the held word, or the fill word when nothing is held.
    task automatic model_consume(output logic [7:0] w);
        w = hold_v ? hold_w : 8'hFF;
        if (!hold_v) und_exp = 1'b1;
        hold_v = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("load_ready_wait", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        hold_v   = 1'b1;
        hold_w   = d;
    endtask

    task automatic spi_frame(input int nbits, input int half, input int load_at, input logic [7:0] load_val);
        int wi, bi;
        cs_n = 1'b0;
        model_consume(miso_exp[0]);
        for (int b = 0; b < nbits; b++) begin
            wi   = b / 8;
            bi   = 7 - (b % 8);
            mosi = mosi_tx[wi][bi];
            wait_clk(half);
            if (b == 0) check("active_in_frame", {31'd0, active}, 32'd1);
            miso_got[wi][bi] = miso;
            sclk = 1'b1;
            if (b % 8 == 7) rx_exp.push_back(mosi_tx[wi]);
            wait_clk(half);
            sclk = 1'b0;
            if (b % 8 == 7) model_consume(miso_exp[wi + 1]);
            if (b == load_at) load(load_val);
        end
        wait_clk(half);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00;
        hold_v = 1'b0; hold_w = 8'h00; und_exp = 1'b0;
`ifdef SPI_TARGET_UNDERRUN_EN
        und_clr = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            mosi_tx[i] = 8'h00; miso_got[i] = 8'h00; miso_exp[i] = 8'h00;
        end

        // Scoreboard: every RX_VALID pulse must match the next completed MOSI word.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && rx_valid) begin
                    rx_pulses++;
                    if (rx_exp.size() == 0) check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                    else                    check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
                end
            end
        join_none

        wait_clk(4);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // Single word, TX 0xA5 against MOSI 0x3C.
        load(8'hA5);
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
        mosi_tx[0] = 8'h3C;
        pulses_before = rx_pulses;
        spi_frame(8, 5, -1, 8'h00);
        check("a5_miso_model", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});
        check("a5_miso_literal", {24'd0, miso_got[0]}, 32'h0000_00A5);
        check("a5_rx_literal", {24'd0, rx_data}, 32'h0000_003C);
        check("a5_pulses", rx_pulses - pulses_before, 32'd1);
        check("a5_active_after", {31'd0, active}, 32'd0);
        check("a5_tx_ready_after", {31'd0, tx_ready}, 32'd1);

        // No TX word: fill word goes out.
`ifdef SPI_TARGET_UNDERRUN_EN
        und_clr = 1'b1; wait_clk(1); und_clr = 1'b0; und_exp = 1'b0;
`endif
        mosi_tx[0] = 8'h81;
        spi_frame(8, 5, -1, 8'h00);
        check("fill_miso_model", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});
        check("fill_miso_literal", {24'd0, miso_got[0]}, 32'h0000_00FF);
`ifdef SPI_TARGET_UNDERRUN_EN
        check("underrun_set", {31'd0, und}, {31'd0, und_exp});
        wait_clk(5);
        check("underrun_sticky", {31'd0, und}, 32'd1);
        und_clr = 1'b1; wait_clk(1); und_clr = 1'b0; und_exp = 1'b0;
        check("underrun_cleared", {31'd0, und}, 32'd0);
`endif

        // Two words per frame, second TX word loaded during word 1.
        load(8'h12);
        mosi_tx[0] = 8'hC3; mosi_tx[1] = 8'h5A;
        pulses_before = rx_pulses;
        spi_frame(16, 5, 2, 8'h34);
        check("two_w0_model", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});
        check("two_w1_model", {24'd0, miso_got[1]}, {24'd0, miso_exp[1]});
        check("two_w0_literal", {24'd0, miso_got[0]}, 32'h0000_0012);
        check("two_w1_literal", {24'd0, miso_got[1]}, 32'h0000_0034);
        check("two_pulses", rx_pulses - pulses_before, 32'd2);
        check("two_rx_last", {24'd0, rx_data}, 32'h0000_005A);

        // Frame aborted after 5 bits, then a full frame.
        load(8'h77);
        mosi_tx[0] = 8'hE7;
        pulses_before = rx_pulses;
        spi_frame(5, 5, -1, 8'h00);
        check("partial_miso", {27'd0, miso_got[0][7:3]}, {27'd0, miso_exp[0][7:3]});
        check("partial_pulses", rx_pulses - pulses_before, 32'd0);
        check("partial_rx_held", {24'd0, rx_data}, 32'h0000_005A);
        mosi_tx[0] = 8'h96;
        spi_frame(8, 5, -1, 8'h00);
        check("after_partial_rx", {24'd0, rx_data}, 32'h0000_0096);
        check("after_partial_miso", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});

        // Minimum legal SCLK high/low time, 16-bit loopback.
        load(8'hC9);
        mosi_tx[0] = 8'hDE; mosi_tx[1] = 8'hAD;
        pulses_before = rx_pulses;
        spi_frame(16, 4, 3, 8'h3B);
        check("min_w0", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});
        check("min_w1", {24'd0, miso_got[1]}, {24'd0, miso_exp[1]});
        check("min_w16_literal", {16'd0, miso_got[0], miso_got[1]}, 32'h0000_C93B);
        check("min_pulses", rx_pulses - pulses_before, 32'd2);
        check("min_rx_last", {24'd0, rx_data}, 32'h0000_00AD);

        // Reset at bit 3 of a frame; CS_n stays low across release.
        load(8'h5E);
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1; sclk = 1'b1; wait_clk(5);
            sclk = 1'b0; wait_clk(5);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_active", {31'd0, active}, 32'd0);
        hold_v = 1'b0; und_exp = 1'b0; rx_exp.delete();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        check("held_cs_active", {31'd0, active}, 32'd1);
        load(8'h6C);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1; wait_clk(5);
            sclk = 1'b0; wait_clk(5);
        end
        check("held_cs_no_consume", {31'd0, tx_ready}, 32'd0);
        cs_n = 1'b1;
        wait_clk(8);
        mosi_tx[0] = 8'h0F;
        spi_frame(8, 5, -1, 8'h00);
        check("fresh_frame_miso", {24'd0, miso_got[0]}, 32'h0000_006C);
        check("fresh_frame_model", {24'd0, miso_got[0]}, {24'd0, miso_exp[0]});
        check("fresh_frame_rx", {24'd0, rx_data}, 32'h0000_000F);

        wait_clk(5);
        check("rx_words_outstanding", rx_exp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
